// File: rtl/rv32_data_memory.sv
// rv32_data_memory: single-port 32-bit word RAM answering the pipeline core's data-memory port.
// Build macro DMEM_BYTE_STROBE_EN adds per-byte write enables on input mem_byte_en.
//
// state  | meaning
// CLEAR  | zero-filling the array one word per cycle; core requests ignored
// READY  | servicing loads and stores; terminal until the next reset
module rv32_data_memory #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  mem_byte_en,
`endif
    output logic [31:0] mem_read_data,
    output logic        mem_read_valid,
    output logic        mem_ready,
    input  logic        err_clear,
    output logic        misaligned_err,
    output logic        range_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic          in_range;
    logic          aligned;
    logic          legal;
    logic          req;
    logic [AW-1:0] idx;
    logic [3:0]    wstrb;

    // BASE_ADDR is word aligned, so the low offset bits equal the address low bits.
    assign off      = mem_address - BASE_ADDR;
    assign in_range = (mem_address >= BASE_ADDR) && ({2'b00, off[31:2]} < DEPTH_WORDS);
    assign aligned  = (off[1:0] == 2'b00);
    assign legal    = in_range && aligned;
    assign idx      = off[AW+1:2];
    assign req      = mem_write_en || mem_read_en;

`ifdef DMEM_BYTE_STROBE_EN
    assign wstrb = mem_byte_en;
`else
    assign wstrb = 4'hF;
`endif

    assign mem_ready = (state == ST_READY);

    // Array is deliberately not reset; CLEAR provides the zero fill.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (mem_write_en && legal) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= mem_write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_cnt        <= '0;
            mem_read_data  <= '0;
            mem_read_valid <= 1'b0;
            misaligned_err <= 1'b0;
            range_err      <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    mem_read_valid <= 1'b0;
                    clr_cnt        <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    mem_read_valid <= mem_read_en;
                    if (mem_read_en) begin
                        mem_read_data <= legal ? mem[idx] : '0;
                    end
                    // A fresh error in the same cycle as err_clear takes priority.
                    misaligned_err <= (req && !aligned)  || (misaligned_err && !err_clear);
                    range_err      <= (req && !in_range) || (range_err && !err_clear);
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_data_memory.sv
// Randomized self-checking bench for rv32_data_memory (DEPTH_WORDS=16, BASE_ADDR=0).
// Expected outputs come from a word-array reference model updated once per clock edge.
module tb_rv32_data_memory;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_write_data = '0;
    logic        mem_write_en = 1'b0;
    logic        mem_read_en = 1'b0;
    logic [3:0]  mem_byte_en = 4'hF;
    logic [31:0] mem_read_data;
    logic        mem_read_valid;
    logic        mem_ready;
    logic        err_clear = 1'b0;
    logic        misaligned_err;
    logic        range_err;

    rv32_data_memory #(
        .DEPTH_WORDS   (DEPTH),
        .BASE_ADDR     (BASE),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_write_en  (mem_write_en),
        .mem_read_en   (mem_read_en),
`ifdef DMEM_BYTE_STROBE_EN
        .mem_byte_en   (mem_byte_en),
`endif
        .mem_read_data (mem_read_data),
        .mem_read_valid(mem_read_valid),
        .mem_ready     (mem_ready),
        .err_clear     (err_clear),
        .misaligned_err(misaligned_err),
        .range_err     (range_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference model
    logic [31:0] mdl [DEPTH];
    int          m_clear_left;
    bit          m_ready, m_valid, m_mis, m_rng;
    logic [31:0] m_data;

    task automatic model_reset();
        m_ready      = 1'b0;
        m_clear_left = DEPTH;
        m_valid      = 1'b0;
        m_data       = '0;
        m_mis        = 1'b0;
        m_rng        = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    task automatic model_edge();
        longint unsigned a;
        bit              ok_rng, ok_al, rq;
        int              wi;
        logic [3:0]      be;
        if (!m_ready) begin
            m_valid = 1'b0;
            m_clear_left--;
            if (m_clear_left == 0) m_ready = 1'b1;
        end else begin
            a      = longint'(mem_address);
            ok_rng = (a >= longint'(BASE)) && (((a - longint'(BASE)) / 4) < DEPTH);
            ok_al  = (a % 4) == 0;
            wi     = ok_rng ? int'((a - longint'(BASE)) / 4) : 0;
            rq     = mem_read_en || mem_write_en;
`ifdef DMEM_BYTE_STROBE_EN
            be = mem_byte_en;
`else
            be = 4'hF;
`endif
            m_valid = mem_read_en;
            if (mem_read_en) m_data = (ok_rng && ok_al) ? mdl[wi] : 32'h0;
            if (mem_write_en && ok_rng && ok_al) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[wi][8*b +: 8] = mem_write_data[8*b +: 8];
            end
            m_mis = (rq && !ok_al)  ? 1'b1 : (err_clear ? 1'b0 : m_mis);
            m_rng = (rq && !ok_rng) ? 1'b1 : (err_clear ? 1'b0 : m_rng);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(mem_read_valid), 32'(m_valid));
        chk({tag, ".data"},  mem_read_data,       m_data);
        chk({tag, ".ready"}, 32'(mem_ready),      32'(m_ready));
        chk({tag, ".mis"},   32'(misaligned_err), 32'(m_mis));
        chk({tag, ".rng"},   32'(range_err),      32'(m_rng));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wd, input bit we,
                         input bit re, input bit ec, input logic [3:0] be);
        mem_address    = addr;
        mem_write_data = wd;
        mem_write_en   = we;
        mem_read_en    = re;
        err_clear      = ec;
        mem_byte_en    = be;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'hF);
    endtask

    task automatic drive_random();
        logic [31:0] addr;
        if ($urandom_range(0, 9) == 0) addr = $urandom();
        else addr = $urandom_range(0, 4 * DEPTH + 8);
        drive(addr, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    endtask

    // Called away from a clock edge; asserts reset, checks async clear, releases on a negedge.
    task automatic do_reset(input string tag);
        idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        model_reset();
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // CLEAR with random traffic that must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            drive_random();
            tick("clear");
        end
        chk("ready_after_clear", 32'(mem_ready), 32'h1);

        for (int i = 0; i < DEPTH; i++) begin
            drive(32'(4 * i), 32'h0, 1'b0, 1'b1, 1'b0, 4'hF);
            tick("zero_rd");
            chk("zero_word", mem_read_data, 32'h0);
        end

        drive(32'h8, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'hF);
        tick("wr8");
        drive(32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF);
        tick("rd8");
        chk("rd8_data", mem_read_data, 32'hDEADBEEF);
        chk("rd8_valid", 32'(mem_read_valid), 32'h1);

        drive(32'h8, 32'h12345678, 1'b1, 1'b1, 1'b0, 4'hF);
        tick("rw8");
        chk("read_first", mem_read_data, 32'hDEADBEEF);
        drive(32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF);
        tick("rd8_new");
        chk("read_new", mem_read_data, 32'h12345678);
        idle();
        tick("idle");
        chk("valid_drop", 32'(mem_read_valid), 32'h0);

        drive(32'h41, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 4'hF);
        tick("wr41");
        drive(32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF);
        tick("rd40");
        chk("rd40_data", mem_read_data, 32'h0);
        chk("rd40_mis", 32'(misaligned_err), 32'h1);
        chk("rd40_rng", 32'(range_err), 32'h1);
        drive(32'h3, 32'h0, 1'b0, 1'b1, 1'b1, 4'hF);
        tick("clr_rd3");
        chk("set_wins_mis", 32'(misaligned_err), 32'h1);
        chk("clear_rng", 32'(range_err), 32'h0);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'hF);
        tick("errclr");

`ifdef DMEM_BYTE_STROBE_EN
        drive(32'h4, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'hF);
        tick("be_fill");
        drive(32'h4, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0101);
        tick("be_wr");
        drive(32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0);
        tick("be_rd");
        chk("byte_lanes", mem_read_data, 32'hFF00FF00);
`endif

        for (int i = 0; i < 600; i++) begin
            drive_random();
            tick("rand");
        end

        // Reset during an active read pulse
        drive(32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF);
        tick("pre_rst_rd");
        #2;
        do_reset("rst_mid_read");
        for (int i = 0; i < DEPTH; i++) begin
            drive_random();
            tick("clear2");
        end

        // Reset seven cycles into CLEAR
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'hF);
        tick("busy");
        #2;
        do_reset("rst_pre");
        for (int i = 0; i < 7; i++) tick("clear3");
        #2;
        do_reset("rst_mid_clear");
        for (int i = 0; i < DEPTH; i++) tick("clear4");
        chk("ready_after_reclear", 32'(mem_ready), 32'h1);

        for (int i = 0; i < 200; i++) begin
            drive_random();
            tick("rand2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
